// File: rtl/ghost_pos_update.sv
// ghost_pos_update: advances the ghost position per movement tick, commits turns only on
// tile centres, sequences the house exit and handles the horizontal tunnel wrap.
`default_nettype none

module ghost_pos_update #(
  parameter int START_X = 320,
  parameter int START_Y = 240,
  parameter int DOOR_Y  = 208,
  parameter int TILE    = 16,
  parameter int STEP    = 2,
  parameter int X_MIN   = 0,
  parameter int X_MAX   = 624
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        move_tick_i,
  input  logic [3:0]  move_direction_i,
  input  logic [3:0]  valid_moves_i,
  input  logic        release_i,
  input  logic        respawn_i,
  input  logic        freeze_i,
  output logic [10:0] ghost_pos_x_o,
  output logic [9:0]  ghost_pos_y_o,
  output logic [3:0]  prev_direction_o,
  output logic        at_center_o,
  output logic        moving_o
);

  localparam int TILE_BITS = $clog2(TILE);

  localparam logic [10:0] C_START_X = 11'(START_X);
  localparam logic [9:0]  C_START_Y = 10'(START_Y);
  localparam logic [9:0]  C_DOOR_Y  = 10'(DOOR_Y);
  localparam logic [10:0] C_STEP_X  = 11'(STEP);
  localparam logic [9:0]  C_STEP_Y  = 10'(STEP);
  localparam logic [10:0] C_X_MIN   = 11'(X_MIN);
  localparam logic [10:0] C_X_MAX   = 11'(X_MAX);

  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_UP    = 4'b0010;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXIT = 2'd1,
    S_ROAM = 2'd2
  } state_t;

  state_t      state_q;
  logic [10:0] x_q;
  logic [9:0]  y_q;
  logic [3:0]  dir_q;
  logic        moving_q;

  logic        at_center_w;
  logic        req_onehot_w;
  logic        go_w;
  logic [3:0]  dir_sel_w;
  logic [10:0] x_d;
  logic [9:0]  y_d;
  logic [9:0]  y_exit_w;

  assign at_center_w  = (x_q[TILE_BITS-1:0] == '0) && (y_q[TILE_BITS-1:0] == '0);
  assign req_onehot_w = (move_direction_i != 4'b0000) &&
                        ((move_direction_i & (move_direction_i - 4'd1)) == 4'b0000);
  assign y_exit_w     = y_q - C_STEP_Y;

  // Direction choice only happens on a centre; mid-tile the committed direction is forced.
  always_comb begin
    dir_sel_w = dir_q;
    go_w      = 1'b1;
    x_d       = x_q;
    y_d       = y_q;
    if (at_center_w) begin
      if (req_onehot_w && ((move_direction_i & valid_moves_i) != 4'b0000)) begin
        dir_sel_w = move_direction_i;
      end else if ((dir_q & valid_moves_i) == 4'b0000) begin
        go_w = 1'b0;
      end
    end
    case (dir_sel_w)
      DIR_RIGHT: x_d = (x_q == C_X_MAX) ? C_X_MIN : x_q + C_STEP_X;
      DIR_LEFT:  x_d = (x_q == C_X_MIN) ? C_X_MAX : x_q - C_STEP_X;
      DIR_UP:    y_d = y_q - C_STEP_Y;
      DIR_DOWN:  y_d = y_q + C_STEP_Y;
      default:   go_w = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      x_q      <= C_START_X;
      y_q      <= C_START_Y;
      dir_q    <= DIR_UP;
      moving_q <= 1'b0;
    end else if (respawn_i) begin
      state_q  <= S_IDLE;
      x_q      <= C_START_X;
      y_q      <= C_START_Y;
      dir_q    <= DIR_UP;
      moving_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (release_i && !freeze_i) begin
            state_q <= S_EXIT;
          end
          if (move_tick_i) begin
            moving_q <= 1'b0;
          end
        end
        S_EXIT: begin
          if (move_tick_i) begin
            if (freeze_i) begin
              moving_q <= 1'b0;
            end else begin
              y_q      <= y_exit_w;
              moving_q <= 1'b1;
              if (y_exit_w == C_DOOR_Y) begin
                state_q <= S_ROAM;
                dir_q   <= DIR_LEFT;
              end else begin
                dir_q   <= DIR_UP;
              end
            end
          end
        end
        S_ROAM: begin
          if (move_tick_i) begin
            if (freeze_i || !go_w) begin
              moving_q <= 1'b0;
            end else begin
              x_q      <= x_d;
              y_q      <= y_d;
              dir_q    <= dir_sel_w;
              moving_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ghost_pos_x_o    = x_q;
  assign ghost_pos_y_o    = y_q;
  assign prev_direction_o = dir_q;
  assign at_center_o      = at_center_w;
  assign moving_o         = moving_q;

endmodule

`default_nettype wire

// File: tb/tb_ghost_pos_update.sv
// tb_ghost_pos_update: directed ghost movement scenarios; a monitor compares DUT state
// after each tick (or explicit check request) against queued expectations.
`default_nettype none

module tb_ghost_pos_update;

  logic        clk;
  logic        rst_n;
  logic        move_tick_i;
  logic [3:0]  move_direction_i;
  logic [3:0]  valid_moves_i;
  logic        release_i;
  logic        respawn_i;
  logic        freeze_i;
  logic [10:0] ghost_pos_x_o;
  logic [9:0]  ghost_pos_y_o;
  logic [3:0]  prev_direction_o;
  logic        at_center_o;
  logic        moving_o;

  typedef struct {
    string       name;
    logic [10:0] x;
    logic [9:0]  y;
    logic [3:0]  d;
    logic        mv;
    bit          chk_mv;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   failures;
  bit   chk_req;
  bit   tick_s;

  ghost_pos_update dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .move_tick_i      (move_tick_i),
    .move_direction_i (move_direction_i),
    .valid_moves_i    (valid_moves_i),
    .release_i        (release_i),
    .respawn_i        (respawn_i),
    .freeze_i         (freeze_i),
    .ghost_pos_x_o    (ghost_pos_x_o),
    .ghost_pos_y_o    (ghost_pos_y_o),
    .prev_direction_o (prev_direction_o),
    .at_center_o      (at_center_o),
    .moving_o         (moving_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [10:0] x, input logic [9:0] y, input logic [3:0] d,
                              input logic mv, input bit cm, input string nm);
    exp_t e;
    e.name = nm; e.x = x; e.y = y; e.d = d; e.mv = mv; e.chk_mv = cm;
    return e;
  endfunction

  // Monitor: compares after every sampled tick edge, or when the driver requests a check.
  initial begin
    exp_t e;
    logic ac;
    forever begin
      @(posedge clk);
      tick_s = move_tick_i;
      @(negedge clk);
      if (tick_s || chk_req) begin
        chk_req = 1'b0;
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL no_expectation: DUT output with empty scoreboard at %0t", $time);
        end else begin
          e  = q.pop_front();
          ac = (e.x[3:0] == 4'd0) && (e.y[3:0] == 4'd0);
          if (ghost_pos_x_o !== e.x || ghost_pos_y_o !== e.y || prev_direction_o !== e.d ||
              at_center_o !== ac || (e.chk_mv && moving_o !== e.mv)) begin
            failures++;
            $display("FAIL %s: got x=%0d y=%0d dir=%b ac=%b mv=%b, expected x=%0d y=%0d dir=%b ac=%b mv=%b",
                     e.name, ghost_pos_x_o, ghost_pos_y_o, prev_direction_o, at_center_o, moving_o,
                     e.x, e.y, e.d, ac, e.mv);
          end
        end
      end
    end
  end

  task automatic do_tick(input logic [3:0] m, input logic [3:0] v, input logic fr, input logic rel,
                         input logic [10:0] ex, input logic [9:0] ey, input logic [3:0] ed,
                         input logic emv, input bit cm, input string nm);
    @(negedge clk);
    move_tick_i = 1'b1; move_direction_i = m; valid_moves_i = v;
    freeze_i = fr; release_i = rel;
    q.push_back(mk(ex, ey, ed, emv, cm, nm));
    @(posedge clk);
    #1;
    move_tick_i = 1'b0; freeze_i = 1'b0; release_i = 1'b0;
  endtask

  task automatic pulse(input logic rel, input logic resp);
    @(negedge clk);
    release_i = rel; respawn_i = resp;
    @(posedge clk);
    #1;
    release_i = 1'b0; respawn_i = 1'b0;
  endtask

  task automatic request_check(input logic [10:0] ex, input logic [9:0] ey, input logic [3:0] ed,
                               input logic emv, input bit cm, input string nm);
    q.push_back(mk(ex, ey, ed, emv, cm, nm));
    chk_req = 1'b1;
    @(negedge clk);
    #1;
  endtask

  initial begin
    checks = 0; failures = 0; chk_req = 1'b0; tick_s = 1'b0;
    rst_n = 1'b0; move_tick_i = 1'b0; move_direction_i = 4'b0000; valid_moves_i = 4'b0000;
    release_i = 1'b0; respawn_i = 1'b0; freeze_i = 1'b0;

    #2;
    request_check(11'd320, 10'd240, 4'b0010, 1'b0, 1'b1, "reset_state");
    #1 rst_n = 1'b1;

    // Release and tick together in IDLE: EXIT entered, but no step yet.
    do_tick(4'b0000, 4'b0000, 1'b0, 1'b1, 11'd320, 10'd240, 4'b0010, 1'b0, 1'b1, "release_tick");
    for (int i = 1; i <= 16; i++)
      do_tick(4'b0100, 4'b0100, 1'b0, 1'b0, 11'd320, 10'(240 - 2*i),
              (i == 16) ? 4'b1000 : 4'b0010, 1'b1, 1'b1, "exit_step");

    do_tick(4'b0010, 4'b1010, 1'b0, 1'b0, 11'd320, 10'd206, 4'b0010, 1'b1, 1'b1, "commit_up");
    for (int i = 1; i <= 7; i++)
      do_tick(4'b1000, 4'b1010, 1'b0, 1'b0, 11'd320, 10'(206 - 2*i), 4'b0010, 1'b1, 1'b1, "midtile_hold");
    do_tick(4'b1000, 4'b1010, 1'b0, 1'b0, 11'd318, 10'd192, 4'b1000, 1'b1, 1'b1, "commit_left");
    for (int i = 1; i <= 7; i++)
      do_tick(4'b0010, 4'b0101, 1'b0, 1'b0, 11'(318 - 2*i), 10'd192, 4'b1000, 1'b1, 1'b1, "left_run");

    do_tick(4'b0010, 4'b0101, 1'b0, 1'b0, 11'd304, 10'd192, 4'b1000, 1'b0, 1'b1, "blocked");
    do_tick(4'b0011, 4'b1000, 1'b0, 1'b0, 11'd302, 10'd192, 4'b1000, 1'b1, 1'b1, "multi_hot");

    for (int i = 1; i <= 151; i++)
      do_tick(4'b1000, 4'b1000, 1'b0, 1'b0, 11'(302 - 2*i), 10'd192, 4'b1000, 1'b1, 1'b1, "to_tunnel");
    do_tick(4'b1000, 4'b1000, 1'b0, 1'b0, 11'd624, 10'd192, 4'b1000, 1'b1, 1'b0, "wrap_left");
    for (int i = 1; i <= 8; i++)
      do_tick(4'b1000, 4'b1000, 1'b0, 1'b0, 11'(624 - 2*i), 10'd192, 4'b1000, 1'b1, 1'b1, "after_wrap");

    for (int i = 0; i < 5; i++)
      do_tick(4'b1000, 4'b1000, 1'b1, 1'b0, 11'd608, 10'd192, 4'b1000, 1'b0, 1'b1, "freeze");

    pulse(1'b0, 1'b1);
    request_check(11'd320, 10'd240, 4'b0010, 1'b0, 1'b0, "respawn");

    pulse(1'b1, 1'b0);
    do_tick(4'b0000, 4'b0000, 1'b0, 1'b0, 11'd320, 10'd238, 4'b0010, 1'b1, 1'b1, "exit_again");
    pulse(1'b1, 1'b1);
    request_check(11'd320, 10'd240, 4'b0010, 1'b0, 1'b0, "respawn_over_release");
    do_tick(4'b0000, 4'b0000, 1'b0, 1'b0, 11'd320, 10'd240, 4'b0010, 1'b0, 1'b1, "idle_hold");

    pulse(1'b1, 1'b0);
    do_tick(4'b0000, 4'b0000, 1'b0, 1'b0, 11'd320, 10'd238, 4'b0010, 1'b1, 1'b1, "exit3_a");
    do_tick(4'b0000, 4'b0000, 1'b0, 1'b0, 11'd320, 10'd236, 4'b0010, 1'b1, 1'b1, "exit3_b");

    // Asynchronous reset between edges; the check lands before the next rising edge.
    @(posedge clk);
    #1 rst_n = 1'b0;
    request_check(11'd320, 10'd240, 4'b0010, 1'b0, 1'b1, "async_reset");
    rst_n = 1'b1;

    repeat (4) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
